stage0_fetch: RTL and testbench
===============================

// Module: stage0_fetch
// PURPOSE
// - Instruction-fetch stage 0: boot ROM, 32-bit data/program RAM and a source mux in one block.
// - Both memories are addressed by the program counter pc.
// - instruction_binary comes from RAM when execute_from_ram=1, otherwise from boot ROM.
// - Feeds the decode stage; CPU boots from ROM, then switches to RAM-resident code.
// PARAMETERS
// - RAM_AWIDTH   16        RAM word-address width; depth = 2**RAM_AWIDTH 32-bit words
// - ROM_AWIDTH   8         ROM word-address width; depth = 2**ROM_AWIDTH 32-bit words
// - DATA_WIDTH   32        word width; fixed at 32, other values unsupported
// PORTS
// - clk               in   1   single clock, rising-edge active
// - reset             in   1   synchronous, active-high reset
// - pc                in   16  program counter; word address for both RAM and ROM
// - execute_from_ram  in   1   1: fetch from RAM, 0: fetch from boot ROM
// - ram_is_write      in   1   RAM write enable, sampled on rising clk
// - ram_in            in   32  RAM write data
// - instruction_binary out 32  fetched instruction word
// - ram_value         out 32  RAM word at pc (async read), debug/observe
// - rom_value         out 32  boot-ROM word at pc (async read), debug/observe
// BEHAVIOUR
// - Address: ram_address = pc[RAM_AWIDTH-1:0]; brom_address = pc; no translation, no byte offset.
// - RAM write: at rising clk with ram_is_write=1 and reset=0, mem[pc] <= ram_in.
// - Writes are ignored in any cycle with reset=1.
// - RAM read: combinational, ram_value = mem[pc].
// - Read-during-write: before the edge ram_value shows old data; after the edge it shows ram_in.
// - RAM contents are not cleared by reset; power-up contents are undefined (X in simulation).
// - ROM: combinational lookup, read-only, contents fixed at elaboration:
//   - word 0x0044 = 0x00000234
//   - every other in-range word = 0x00000000
// - ROM out of range: pc >= 2**ROM_AWIDTH -> rom_value = 0x00000000; upper pc bits are never aliased.
// - Mux: instruction_binary = execute_from_ram ? ram_value : rom_value.
// - Latency: combinational; a change on pc or execute_from_ram is reflected with zero cycles of latency.
// - Reset: no registered outputs in the base build, so reset only blocks RAM writes.
// - No handshake: pc is assumed stable whenever the consumer samples the output.
// CONFIGURATION
// - STAGE0_REG_OUT_EN defined:
//   - instruction_binary is registered at rising clk; 1-cycle latency from pc/execute_from_ram.
//   - The register is loaded with the same mux result; the registered read sees RAM contents before any same-edge write.
//   - reset=1 sets instruction_binary to 0x00000000 on the next edge.
// - STAGE0_REG_OUT_EN undefined: purely combinational instruction_binary as described above.
// - ram_value and rom_value stay combinational in both builds.
// TESTING
// - ROM fetch: pc=0x0044, execute_from_ram=0 -> instruction_binary=0x00000234, rom_value=0x00000234.
// - RAM write/fetch:
//   - Stimulus: pc=0x0044, ram_in=0xE5F84AB1, ram_is_write=1, one rising clk, then ram_is_write=0, execute_from_ram=1.
//   - Required: instruction_binary=0xE5F84AB1.
// - Mux switch: keep pc=0x0044 and toggle execute_from_ram 1->0->1.
//   - Required: output alternates 0xE5F84AB1 / 0x00000234 / 0xE5F84AB1 with no clock edge needed.
// - Reset blocks write: reset=1, ram_is_write=1, pc=0x0010, ram_in=0x12345678, one edge -> mem[0x0010] unchanged.
// - ROM default/out-of-range: pc=0x0000 -> rom_value=0; pc=0x0100 (ROM_AWIDTH=8) -> rom_value=0.
// - STAGE0_REG_OUT_EN:
//   - After reset, instruction_binary=0.
//   - pc=0x0044, execute_from_ram=0: output becomes 0x00000234 only after the next rising edge.

Source files
------------

// File: rtl/stage0_fetch_if.sv
// Fetch-stage bus: program counter, source select, RAM write port and fetched words.
// Latency: n/a (signal bundle only).
// Backpressure: none; pc is held stable by the consumer while it samples the outputs.
interface stage0_fetch_if;
  logic [15:0] pc;
  logic        execute_from_ram;
  logic        ram_is_write;
  logic [31:0] ram_in;
  logic [31:0] instruction_binary;
  logic [31:0] ram_value;
  logic [31:0] rom_value;

  // Core side: drives pc/select/write port, consumes fetched words.
  modport master (
    output pc, execute_from_ram, ram_is_write, ram_in,
    input  instruction_binary, ram_value, rom_value
  );

  // Fetch stage side.
  modport slave (
    input  pc, execute_from_ram, ram_is_write, ram_in,
    output instruction_binary, ram_value, rom_value
  );
endinterface

// File: rtl/stage0_fetch.sv
// Instruction fetch stage 0: boot ROM + program RAM, both addressed by pc, muxed by execute_from_ram.
// Latency: combinational by default; 1 cycle on instruction_binary when STAGE0_REG_OUT_EN is defined.
// Backpressure: none; reset only blocks RAM writes (and clears the output register in the registered build).
module stage0_fetch #(
  parameter int RAM_AWIDTH = 16,
  parameter int ROM_AWIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  stage0_fetch_if.slave  bus
);

  // Boot entry point: the only non-zero word in the boot ROM.
  localparam logic [ROM_AWIDTH-1:0] BOOT_WORD_IDX = ROM_AWIDTH'(16'h0044);
  localparam logic [31:0]           BOOT_WORD     = 32'h0000_0234;

  logic [DATA_WIDTH-1:0] mem [0:(2**RAM_AWIDTH)-1];
  logic [RAM_AWIDTH-1:0] ram_addr;
  logic [ROM_AWIDTH-1:0] rom_idx;
  logic                  rom_in_range;
  logic [31:0]           rom_word;
  logic [31:0]           fetch_mux;

  // pc is a word address for both memories; no byte offset, no translation.
  assign ram_addr     = bus.pc[RAM_AWIDTH-1:0];
  assign rom_idx      = bus.pc[ROM_AWIDTH-1:0];
  // Upper pc bits must be zero for a ROM hit so high addresses never alias onto ROM words.
  assign rom_in_range = ((bus.pc >> ROM_AWIDTH) == 16'd0);

  // RAM write port; contents are deliberately not cleared by reset, only writes are blocked.
  always_ff @(posedge clk) begin
    if (!reset && bus.ram_is_write) begin
      mem[ram_addr] <= bus.ram_in;
    end
  end

  // Boot ROM lookup: fixed contents, zero everywhere except the boot entry word.
  always_comb begin
    rom_word = 32'h0000_0000;
    if (rom_in_range && (rom_idx == BOOT_WORD_IDX)) begin
      rom_word = BOOT_WORD;
    end
  end

  // Asynchronous reads: before a write edge ram_value shows old data, after it the new word.
  assign bus.ram_value = mem[ram_addr];
  assign bus.rom_value = rom_word;

  // Source select: RAM-resident code once the core leaves boot ROM.
  assign fetch_mux = bus.execute_from_ram ? bus.ram_value : bus.rom_value;

`ifdef STAGE0_REG_OUT_EN
  logic [31:0] instr_q;

  // Output register samples the mux before any same-edge RAM write lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= 32'h0000_0000;
    end else begin
      instr_q <= fetch_mux;
    end
  end

  assign bus.instruction_binary = instr_q;
`else
  assign bus.instruction_binary = fetch_mux;
`endif

endmodule

// File: tb/tb_stage0_fetch.sv
// Directed bench for stage0_fetch: ROM fetch, RAM write/fetch, mux switching, reset-blocked write, ROM range.
// Latency: expectations follow the build (combinational or STAGE0_REG_OUT_EN registered output).
// Backpressure: none; inputs driven 1 time unit after a rising edge, outputs sampled before the next one.
module tb_stage0_fetch;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  stage0_fetch_if bus_if ();

  stage0_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let instruction_binary reflect the current inputs (no edge needed in the combinational build).
  task automatic settle_ib();
`ifdef STAGE0_REG_OUT_EN
    tick();
`else
    #1;
`endif
  endtask

  task automatic ram_write(input logic [15:0] addr, input logic [31:0] data);
    bus_if.pc           = addr;
    bus_if.ram_in       = data;
    bus_if.ram_is_write = 1'b1;
    tick();
    bus_if.ram_is_write = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset                   = 1'b1;
    bus_if.pc               = 16'h0000;
    bus_if.execute_from_ram = 1'b0;
    bus_if.ram_is_write     = 1'b0;
    bus_if.ram_in           = 32'h0;
    tick();
    tick();

    // Reset state
    chk("rom_pc0", bus_if.rom_value, 32'h0);
`ifdef STAGE0_REG_OUT_EN
    chk("ib_reset", bus_if.instruction_binary, 32'h0);
`endif
    reset = 1'b0;

    // ROM fetch at boot entry
    bus_if.pc = 16'h0044;
    #1;
    chk("rom_boot", bus_if.rom_value, 32'h0000_0234);
`ifdef STAGE0_REG_OUT_EN
    chk("ib_rom_pre_edge", bus_if.instruction_binary, 32'h0);
`endif
    settle_ib();
    chk("ib_rom", bus_if.instruction_binary, 32'h0000_0234);

    // RAM write then fetch from RAM; read-after-edge shows new data
    ram_write(16'h0044, 32'hE5F8_4AB1);
    chk("ram_after_wr", bus_if.ram_value, 32'hE5F8_4AB1);
    bus_if.execute_from_ram = 1'b1;
    settle_ib();
    chk("ib_ram", bus_if.instruction_binary, 32'hE5F8_4AB1);

    // Mux switch 1 -> 0 -> 1 at fixed pc
    bus_if.execute_from_ram = 1'b0;
    settle_ib();
    chk("ib_mux_rom", bus_if.instruction_binary, 32'h0000_0234);
    bus_if.execute_from_ram = 1'b1;
    settle_ib();
    chk("ib_mux_ram", bus_if.instruction_binary, 32'hE5F8_4AB1);

    // Reset blocks a RAM write; preload a known word first
    ram_write(16'h0010, 32'hA5A5_A5A5);
    chk("ram_pre_reset", bus_if.ram_value, 32'hA5A5_A5A5);
    reset               = 1'b1;
    bus_if.ram_in       = 32'h1234_5678;
    bus_if.ram_is_write = 1'b1;
    tick();
    reset               = 1'b0;
    bus_if.ram_is_write = 1'b0;
    #1;
    chk("ram_reset_blk", bus_if.ram_value, 32'hA5A5_A5A5);
`ifdef STAGE0_REG_OUT_EN
    chk("ib_cleared", bus_if.instruction_binary, 32'h0);
`endif
    settle_ib();
    chk("ib_ram_10", bus_if.instruction_binary, 32'hA5A5_A5A5);

    // Full 16-bit RAM addressing: 0x0144 and 0xFFFF do not collide with 0x0044
    ram_write(16'h0144, 32'hCAFE_F00D);
    ram_write(16'hFFFF, 32'h0BAD_BEEF);
    bus_if.pc = 16'h0144;
    #1;
    chk("ram_0144", bus_if.ram_value, 32'hCAFE_F00D);
    bus_if.pc = 16'hFFFF;
    #1;
    chk("ram_ffff", bus_if.ram_value, 32'h0BAD_BEEF);
    bus_if.pc = 16'h0044;
    #1;
    chk("ram_0044_kept", bus_if.ram_value, 32'hE5F8_4AB1);

    // ROM defaults and out-of-range (no aliasing of upper pc bits)
    bus_if.execute_from_ram = 1'b0;
    bus_if.pc = 16'h0045;
    #1;
    chk("rom_0045", bus_if.rom_value, 32'h0);
    bus_if.pc = 16'h00FF;
    #1;
    chk("rom_00ff", bus_if.rom_value, 32'h0);
    bus_if.pc = 16'h0100;
    #1;
    chk("rom_0100", bus_if.rom_value, 32'h0);
    bus_if.pc = 16'h0144;
    #1;
    chk("rom_0144_alias", bus_if.rom_value, 32'h0);
    settle_ib();
    chk("ib_rom_oor", bus_if.instruction_binary, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
